// File: rtl/bb_seg7_codes.sv
// Shared 7-segment code table (bit 0 = top ... bit 6 = middle) used by both the
// LCD encoder and the loopback decoder so the two can never disagree.
package bb_seg7_codes;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_ERR = 7'h39;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE
    } rx_state_t;

    // Non-BCD inputs render as the error glyph.
    function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_ERR;
        endcase
    endfunction

endpackage

// File: rtl/bb_seg7_to_bcd.sv
// Inverse of seg7_encode: exact-match lookup of a segment pattern to a BCD digit.
module bb_seg7_to_bcd
    import bb_seg7_codes::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       bad
);

    always_comb begin
        bcd = 4'd0;
        bad = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (seg == seg7_encode(4'(i))) begin
                bcd = 4'(i);
                bad = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bb_lcd_seg_rx.sv
// Loopback monitor for the AC-driven 7-segment LCD: demodulates segments against
// com, checks DC balance over a com=0/com=1 frame and debounces the decoded digit.
module bb_lcd_seg_rx
    import bb_seg7_codes::*;
#(
    parameter int SETTLE        = 16,
    parameter int STABLE_FRAMES = 2,
    parameter int TIMEOUT       = 65535
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       lcdcom,
    input  logic [6:0] lcdseg,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       update,
    output logic [6:0] seg_raw,
    output logic       err_pattern,
    output logic       err_dc,
    output logic       com_lost
);

    logic [1:0]  com_ff;
    logic [6:0]  seg_ff1, seg_ff2;
    logic        com_prev;
    rx_state_t   state;
    logic [15:0] settle_cnt;
    logic [15:0] to_cnt;
    logic [3:0]  stab_cnt, stab_next;
    logic [3:0]  last_val;
    logic [6:0]  demod0;
    logic        pending;

    logic        com_sync, com_edge, lost_evt, frame_bad, dec_bad;
    logic [6:0]  demod;
    logic [3:0]  dec_bcd;

    assign com_sync  = com_ff[1];
    assign com_edge  = com_sync ^ com_prev;
    assign demod     = seg_ff2 ^ {7{com_sync}};
    assign lost_evt  = !com_edge && (to_cnt == 16'(TIMEOUT - 1));
    assign frame_bad = dec_bad || (demod0 != demod);

    bb_seg7_to_bcd u_dec (
        .seg (demod),
        .bcd (dec_bcd),
        .bad (dec_bad)
    );

    // Run length of identical good frames, restarting at 1 on a new value.
    always_comb begin
        stab_next = 4'd1;
        if (stab_cnt != 4'd0 && dec_bcd == last_val)
            stab_next = (stab_cnt == 4'hF) ? stab_cnt : stab_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            com_ff      <= '0;
            seg_ff1     <= '0;
            seg_ff2     <= '0;
            com_prev    <= 1'b0;
            state       <= ST_IDLE;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            stab_cnt    <= '0;
            last_val    <= '0;
            demod0      <= '0;
            pending     <= 1'b0;
            digit       <= '0;
            digit_valid <= 1'b0;
            update      <= 1'b0;
            seg_raw     <= '0;
            err_pattern <= 1'b0;
            err_dc      <= 1'b0;
            com_lost    <= 1'b0;
        end else begin
            com_ff   <= {com_ff[0], lcdcom};
            seg_ff1  <= lcdseg;
            seg_ff2  <= seg_ff1;
            com_prev <= com_sync;
            update   <= 1'b0;

            if (com_edge) begin
                to_cnt   <= '0;
                com_lost <= 1'b0;
            end else if (to_cnt != 16'(TIMEOUT)) begin
                to_cnt <= to_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (com_edge) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    // A glitch on com means the phase is unreliable: drop it entirely.
                    if (com_edge) begin
                        settle_cnt <= '0;
                        pending    <= 1'b0;
                    end else if (settle_cnt == 16'(SETTLE - 1)) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                ST_SAMPLE: begin
                    state      <= com_edge ? ST_SETTLE : ST_IDLE;
                    settle_cnt <= '0;
                    if (!com_sync) begin
                        demod0  <= demod;
                        pending <= 1'b1;
                    end else if (pending && !lost_evt) begin
                        pending     <= 1'b0;
                        seg_raw     <= demod;
                        err_dc      <= (demod0 != demod);
                        err_pattern <= dec_bad;
                        if (frame_bad) begin
                            stab_cnt    <= '0;
                            digit_valid <= 1'b0;
                        end else begin
                            stab_cnt <= stab_next;
                            last_val <= dec_bcd;
                            if (stab_next >= 4'(STABLE_FRAMES)) begin
                                digit       <= dec_bcd;
                                digit_valid <= 1'b1;
                                update      <= (dec_bcd != digit) || !digit_valid;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (lost_evt) begin
                com_lost    <= 1'b1;
                digit_valid <= 1'b0;
                stab_cnt    <= '0;
                pending     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bb_lcd_seg_rx.sv
// Directed bench for bb_lcd_seg_rx: frames of AC-driven segment patterns with
// hand-computed digit, flag, update and timeout expectations.
module tb_bb_lcd_seg_rx;

  logic       clk = 1'b0;
  logic       nrst;
  logic       lcdcom;
  logic [6:0] lcdseg;
  logic [3:0] digit;
  logic       digit_valid;
  logic       update;
  logic [6:0] seg_raw;
  logic       err_pattern;
  logic       err_dc;
  logic       com_lost;

  int checks   = 0;
  int failures = 0;
  int upd_cnt;
  int upd_at;

  always #5 clk = ~clk;

  bb_lcd_seg_rx #(
    .SETTLE        (16),
    .STABLE_FRAMES (2),
    .TIMEOUT       (1000)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .lcdcom      (lcdcom),
    .lcdseg      (lcdseg),
    .digit       (digit),
    .digit_valid (digit_valid),
    .update      (update),
    .seg_raw     (seg_raw),
    .err_pattern (err_pattern),
    .err_dc      (err_dc),
    .com_lost    (com_lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One com half-period; seg is the raw electrode value. Records update pulses
  // and the posedge index (0 = first edge after the com change) of the last one.
  task automatic phase(input logic c, input logic [6:0] seg, input int ncyc);
    @(negedge clk);
    lcdcom  = c;
    lcdseg  = seg;
    upd_cnt = 0;
    upd_at  = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (update) begin
        upd_cnt++;
        upd_at = i;
      end
    end
  endtask

  // Well-formed frame: pattern driven as-is with com=0, inverted with com=1.
  task automatic frame(input logic [6:0] pat);
    phase(1'b0, pat, 200);
    phase(1'b1, pat ^ 7'h7F, 200);
  endtask

  initial begin
    nrst   = 1'b0;
    lcdcom = 1'b0;
    lcdseg = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", digit, 4'h0);
    check("rst_valid", digit_valid, 1'b0);
    check("rst_update", update, 1'b0);
    check("rst_seg_raw", seg_raw, 7'h00);
    check("rst_err_pattern", err_pattern, 1'b0);
    check("rst_err_dc", err_dc, 1'b0);
    check("rst_com_lost", com_lost, 1'b0);
    @(negedge clk);
    nrst = 1'b1;

    // A leading com=1 phase has no com=0 partner and must be ignored.
    phase(1'b1, 7'h4F ^ 7'h7F, 200);
    check("align_seg_raw", seg_raw, 7'h00);
    check("align_valid", digit_valid, 1'b0);

    // Digit 3: first frame only starts the run, second validates it.
    frame(7'h4F);
    check("d3_f1_seg_raw", seg_raw, 7'h4F);
    check("d3_f1_valid", digit_valid, 1'b0);
    check("d3_f1_updates", upd_cnt, 0);
    frame(7'h4F);
    check("d3_f2_updates", upd_cnt, 1);
    // 2 sync + 1 edge + 16 settle -> sample at edge 18, outputs after edge 19.
    check("d3_f2_update_at", upd_at, 19);
    check("d3_f2_digit", digit, 4'h3);
    check("d3_f2_valid", digit_valid, 1'b1);
    check("d3_f2_err_pattern", err_pattern, 1'b0);

    // A single 7 frame does not reach the stable count; 3 returns with no update.
    frame(7'h07);
    check("d7_seg_raw", seg_raw, 7'h07);
    check("d7_updates", upd_cnt, 0);
    check("d7_digit", digit, 4'h3);
    frame(7'h4F);
    check("back3_f1_updates", upd_cnt, 0);
    frame(7'h4F);
    check("back3_f2_updates", upd_cnt, 0);
    check("back3_f2_digit", digit, 4'h3);

    // Error glyph is not a digit.
    frame(7'h39);
    check("e39_err_pattern", err_pattern, 1'b1);
    check("e39_err_dc", err_dc, 1'b0);
    check("e39_valid", digit_valid, 1'b0);
    check("e39_digit", digit, 4'h3);
    frame(7'h4F);
    check("rev_f1_err_pattern", err_pattern, 1'b0);
    check("rev_f1_valid", digit_valid, 1'b0);
    frame(7'h4F);
    check("rev_f2_valid", digit_valid, 1'b1);
    check("rev_f2_updates", upd_cnt, 1);

    // DC fault: 0x06 with com=0, not inverted with com=1 -> demod1 = 0x79.
    phase(1'b0, 7'h06, 200);
    phase(1'b1, 7'h06, 200);
    check("dc_err_dc", err_dc, 1'b1);
    check("dc_seg_raw", seg_raw, 7'h79);
    check("dc_err_pattern", err_pattern, 1'b1);
    check("dc_valid", digit_valid, 1'b0);
    check("dc_digit", digit, 4'h3);

    // Change to 8.
    frame(7'h7F);
    check("d8_f1_valid", digit_valid, 1'b0);
    frame(7'h7F);
    check("d8_f2_digit", digit, 4'h8);
    check("d8_f2_updates", upd_cnt, 1);

    // Last com edge, then hold: edge registered after posedge 2, so the
    // 1000-cycle timeout lands after posedge 1002.
    @(negedge clk);
    lcdcom = 1'b0;
    lcdseg = 7'h7F;
    for (int i = 0; i < 1005; i++) begin
      @(posedge clk);
      #1;
      if (i == 1001) begin
        check("to_before_lost", com_lost, 1'b0);
        check("to_before_valid", digit_valid, 1'b1);
      end
      if (i == 1002) begin
        check("to_at_lost", com_lost, 1'b1);
        check("to_at_valid", digit_valid, 1'b0);
      end
    end
    // The pending com=0 half was dropped, so this com=1 phase is ignored.
    phase(1'b1, 7'h7F ^ 7'h7F, 200);
    check("restart_lost", com_lost, 1'b0);
    check("restart_valid", digit_valid, 1'b0);
    frame(7'h7F);
    check("restart_f1_valid", digit_valid, 1'b0);
    frame(7'h7F);
    check("restart_f2_valid", digit_valid, 1'b1);
    check("restart_f2_updates", upd_cnt, 1);

    // Reset in the settle window of a com=1 phase.
    phase(1'b0, 7'h4F, 200);
    @(negedge clk);
    lcdcom = 1'b1;
    lcdseg = 7'h4F ^ 7'h7F;
    repeat (10) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_digit", digit, 4'h0);
    check("mid_rst_valid", digit_valid, 1'b0);
    check("mid_rst_seg_raw", seg_raw, 7'h00);
    check("mid_rst_com_lost", com_lost, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("post_rst_seg_raw", seg_raw, 7'h00);
    check("post_rst_valid", digit_valid, 1'b0);
    frame(7'h4F);
    check("post_rst_f1_seg_raw", seg_raw, 7'h4F);
    check("post_rst_f1_valid", digit_valid, 1'b0);
    frame(7'h4F);
    check("post_rst_f2_digit", digit, 4'h3);
    check("post_rst_f2_valid", digit_valid, 1'b1);
    check("post_rst_f2_updates", upd_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
